// File: rtl/wrr_burst_arbiter_if.sv
// Requester/resource-side bundle for the weighted round-robin burst arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface wrr_burst_arbiter_if #(
  parameter int N  = 8,
  parameter int WW = 4
);
  logic [N-1:0]         req;
  logic [N-1:0]         last;
  logic [N*WW-1:0]      weight;
  logic                 res_ready;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;
  logic                 beat;

  modport master (
    output req, last, weight, res_ready,
    input  grant, grant_id, busy, beat
  );

  modport slave (
    input  req, last, weight, res_ready,
    output grant, grant_id, busy, beat
  );
endinterface

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter: one registered one-hot grant per burst of
// up to weight[i] beats, ended early by last or by the requester dropping req.
module wrr_burst_arbiter #(
  parameter int N  = 8,
  parameter int WW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wrr_burst_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [WW-1:0]  credit_q, credit_d;
  logic           busy_q, busy_d;

  logic [IW-1:0]  sel;
  logic           found;
  logic [WW-1:0]  sel_weight;
  logic           beat;
  logic           release_now;

  // Rotating priority scan starting at ptr_q.
  always_comb begin : pick
    int cand;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!found && bus.req[cand]) begin
        sel   = IW'(cand);
        found = 1'b1;
      end
    end
    sel_weight = bus.weight[int'(sel)*WW +: WW];
  end

  assign beat = busy_q & bus.req[grant_id_q] & bus.res_ready;

  // A dropped request releases without a beat; otherwise the beat must land.
  assign release_now = (state_q == GRANT) &
                       (~bus.req[grant_id_q] |
                        (beat & (bus.last[grant_id_q] | (credit_q == WW'(1)))));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    grant_d    = grant_q;
    credit_d   = credit_q;

    if ((state_q == IDLE || release_now) && found) begin
      state_d      = GRANT;
      grant_d      = '0;
      grant_d[sel] = 1'b1;
      grant_id_d   = sel;
      credit_d     = (sel_weight == '0) ? WW'(1) : sel_weight;
      ptr_d        = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
    end else if (release_now) begin
      state_d    = IDLE;
      grant_d    = '0;
      grant_id_d = '0;
    end else if (beat) begin
      credit_d = credit_q - WW'(1);
    end

    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      grant_q    <= '0;
      credit_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      grant_q    <= grant_d;
      credit_q   <= credit_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.beat     = beat;
endmodule

// File: doc/wrr_burst_arbiter.md
# wrr_burst_arbiter

Weighted round-robin burst arbiter that shares one downstream resource (bus port, FIFO write side, shared engine) between 8 requesters. Each winner holds a registered one-hot grant for a burst of up to `weight[i]` accepted beats, or until it signals `last` or drops its request. Fairness rotates with a round-robin pointer. It sits between the requester-side `req` vectors and the shared resource's ready signal, and is the burst-capable successor of the plain per-cycle round-robin `arbiter`.

## Interface
- `N`, 8: number of requesters.
- `WW`, 4: width of each per-requester weight field.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N: request per requester; must stay high while the requester wants service.
- `last` input N: `last[i]` marks the current beat of requester i as its final beat; only meaningful while granted.
- `weight` input N*WW: `weight[i*WW +: WW]` is the burst credit for requester i, sampled when i is granted; 0 is treated as 1.
- `res_ready` input 1: shared resource accepts a beat this cycle.
- `grant` output N: registered one-hot grant, or all zeros.
- `grant_id` output $clog2(N): index of the granted requester; 0 when idle.
- `busy` output 1: registered, equals `|grant`.
- `beat` output 1: combinational, `busy & req[grant_id] & res_ready`, i.e. one beat transferred this cycle.

## Operation
- State: `IDLE` / `GRANT`, priority pointer `ptr` (0..N-1), credit counter `credit` (WW bits).
- Selection: the first set bit of `req` scanning `ptr, ptr+1, … N-1, 0, … ptr-1`.
- `IDLE`: if `req != 0`, the following registers load at the next edge:
  - `grant` = one-hot(sel), `grant_id` = sel.
  - `credit` = max(weight[sel], 1).
  - `ptr` = (sel+1) mod N.
  - Move to `GRANT`.
- `GRANT`, with g = `grant_id`. Release occurs at the edge when any of these hold:
  - `req[g]==0`: no beat counted.
  - `beat & last[g]`.
  - `beat & credit==1`.
- `GRANT` without release: on `beat`, `credit` decrements; otherwise all registers hold.
- On release: if `req` (current cycle, including g) is non-zero, re-arbitrate at that edge using the already-advanced `ptr`.
  - The next grant is loaded with no bubble.
  - g may win again only if no other requester is pending.
  - If `req` is zero, go to `IDLE` with `grant=0` and `grant_id=0`.
- `res_ready` low stalls indefinitely; there is no timeout.
- `req` of non-granted requesters does not affect the current burst.
- `last` of non-granted requesters is ignored.

## Timing
- Reset (async assert): `grant=0`, `grant_id=0`, `busy=0`, `ptr=0`, `credit=0`, state `IDLE`.
  - Reset mid-burst clears `grant` immediately, without waiting for a clock edge.
  - Reset release is synchronous to `clk`.
- Grant latency: `req` rises in cycle t → `grant` is valid in cycle t+1.
- A burst of weight w with `res_ready=1` holds the grant for exactly w cycles; the next grant follows in the very next cycle.
- Grant is one-hot or zero at every cycle; it never changes except at a release edge or from `IDLE`.
- `weight` changes only take effect at the next grant load.

## Test plan
- Baseline burst rotation.
  - Stimulus: after reset, all weights=2, `req=8'b1101_1001`, `res_ready=1`, `last=0`, all held.
  - Required: `grant` sequence 01,01,08,08,10,10,40,40,80,80,01,…; `busy=1` throughout, with no gaps.
- Early release by `last`.
  - Stimulus: weight[2]=5, `req=8'b0000_0100` then `8'b0000_0110`; `last[2]=1` on the 2nd beat.
  - Required: `grant=04` for 2 cycles, then `02`; `credit` is discarded.
- Stall, then request drop.
  - Stimulus: granted requester 0 with weight=3, `res_ready=0` for 4 cycles → `grant` holds at 01, `beat=0`.
  - Stimulus: `req[0]` drops while `req[5]=1`.
  - Required: `grant=20` at the next edge.
- Weight 0 and sole requester.
  - Stimulus: weight[7]=0, only `req[7]=1`, `res_ready=1`.
  - Required: `grant=80` every cycle; `grant_id=7`; re-granted back-to-back; `ptr` returns to 0 after each grant.
- Simultaneous release and new request.
  - Stimulus: requester 3 on its final credit beat while `req[1]` and `req[6]` rise in the same cycle, with `ptr=4`.
  - Required: `grant=40` next cycle, then `02` after requester 6 releases.
- Reset mid-burst.
  - Stimulus: assert `rst_n=0` between clock edges during `grant=08`.
  - Required: `grant=0` and `busy=0` immediately.
  - After release with `req=8'b1000_1000`: first grant is `08` (ptr=0).
